// File: rtl/spi_byte_sequencer_pkg.sv
// Shared definitions for the SPI byte sequencer: FSM state encoding and the
// default fill byte used for auto-read transfers.
package spi_byte_sequencer_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_START    = 3'd1;
   localparam logic [2:0] ST_WAIT_BSY = 3'd2;
   localparam logic [2:0] ST_XFER     = 3'd3;
   localparam logic [2:0] ST_CAPT     = 3'd4;

   localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_byte_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags.
// A push on a full FIFO is accepted only when a pop happens in the same cycle;
// a pop on an empty FIFO is ignored.
module spi_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Head of queue is visible without a pop; reads as zero while empty.
   assign rdata = empty ? '0 : mem[rd_ptr];

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop) begin
         count_nxt = count + 1'b1;
      end else if (!do_push && do_pop) begin
         count_nxt = count - 1'b1;
      end
   end

   // Pointers, occupancy and flags; pointers wrap naturally since DEPTH is 2^n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   // Storage array; contents are don't-care while not occupied.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Host-side byte sequencer in front of the SPI byte controller.
// Feeds queued TX bytes (or fill bytes in auto-read mode) over the
// txdata/txstart/busy handshake and queues received bytes for the host.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a TX byte or auto-read count, and RX space
// START     | spi_txstart high for this single cycle
// WAIT_BSY  | holding spi_txdata until the controller raises busy
// XFER      | byte shifting; waiting for busy to drop
// CAPT      | capture spi_rxdata into the RX FIFO unless discarding
module spi_byte_sequencer
   import spi_byte_sequencer_pkg::*;
#(
   parameter int         DEPTH     = 4,
   parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_wr,
   input  logic [7:0] tx_wdata,
   input  logic       rx_rd,
   output logic [7:0] rx_rdata,
   input  logic       auto_cnt_wr,
   input  logic [7:0] auto_cnt_wdata,
   input  logic       rx_discard,
   output logic       tx_full,
   output logic       rx_empty,
   output logic       rx_full,
   output logic       seq_busy,
   output logic [7:0] spi_txdata,
   output logic       spi_txstart,
   input  logic [7:0] spi_rxdata,
   input  logic       spi_busy
);

   logic [2:0] state;
   logic [7:0] auto_cnt;
   logic [7:0] tx_head;
   logic       tx_empty;
   logic       tx_pop;
   logic       rx_push;
   logic       launch;
   logic       use_tx;

   // Launch needs work to do and somewhere to put the reply (unless discarding).
   assign use_tx  = !tx_empty;
   assign launch  = (state == ST_IDLE) && (use_tx || (auto_cnt != 8'd0))
                    && (rx_discard || !rx_full);
   assign tx_pop  = launch && use_tx;
   assign rx_push = (state == ST_CAPT) && !rx_discard;

   assign spi_txstart = (state == ST_START);
   assign seq_busy    = (state != ST_IDLE) || !tx_empty || (auto_cnt != 8'd0);

   spi_byte_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tx_wr),
      .wdata (tx_wdata),
      .pop   (tx_pop),
      .rdata (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   // A full RX FIFO without a same-cycle pop drops the captured byte.
   spi_byte_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_push),
      .wdata (spi_rxdata),
      .pop   (rx_rd),
      .rdata (rx_rdata),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // Transfer sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:     if (launch) state <= ST_START;
            ST_START:    state <= ST_WAIT_BSY;
            ST_WAIT_BSY: if (spi_busy) state <= ST_XFER;
            ST_XFER:     if (!spi_busy) state <= ST_CAPT;
            ST_CAPT:     state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
      end
   end

   // Outgoing byte only changes at launch, so it is stable for the whole transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spi_txdata <= 8'h00;
      end else if (launch) begin
         spi_txdata <= use_tx ? tx_head : FILL_BYTE;
      end
   end

   // Auto-read down-counter; a host write overrides a same-cycle decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         auto_cnt <= 8'd0;
      end else if (auto_cnt_wr) begin
         auto_cnt <= auto_cnt_wdata;
      end else if (launch && !use_tx) begin
         auto_cnt <= auto_cnt - 8'd1;
      end
   end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Bench for spi_byte_sequencer: a behavioural SPI byte controller answers each
// txstart with a random response delay and busy length; expected TX and RX
// byte streams are kept as queues and compared against what the DUT does.
module tb_spi_byte_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_wr;
   logic [7:0] tx_wdata;
   logic       rx_rd;
   logic [7:0] rx_rdata;
   logic       auto_cnt_wr;
   logic [7:0] auto_cnt_wdata;
   logic       rx_discard;
   logic       tx_full;
   logic       rx_empty;
   logic       rx_full;
   logic       seq_busy;
   logic [7:0] spi_txdata;
   logic       spi_txstart;
   logic [7:0] spi_rxdata;
   logic       spi_busy;

   int n_tests = 0;
   int n_fail  = 0;
   int nxfer   = 0;
   int nstart  = 0;
   int resp_min = 1;
   int resp_max = 3;
   bit miso_ones = 1'b0;
   bit saw_rx    = 1'b0;
   logic [7:0] exp_tx_q[$];
   logic [7:0] exp_rx_q[$];

   always #5 clk = ~clk;

   spi_byte_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .tx_wr          (tx_wr),
      .tx_wdata       (tx_wdata),
      .rx_rd          (rx_rd),
      .rx_rdata       (rx_rdata),
      .auto_cnt_wr    (auto_cnt_wr),
      .auto_cnt_wdata (auto_cnt_wdata),
      .rx_discard     (rx_discard),
      .tx_full        (tx_full),
      .rx_empty       (rx_empty),
      .rx_full        (rx_full),
      .seq_busy       (seq_busy),
      .spi_txdata     (spi_txdata),
      .spi_txstart    (spi_txstart),
      .spi_rxdata     (spi_rxdata),
      .spi_busy       (spi_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) if (rst_n && spi_txstart) nstart++;
   always @(negedge clk) if (!rx_empty) saw_rx = 1'b1;

   // Behavioural SPI byte controller (MISO looped to MOSI, or tied high).
   initial begin : spictrl_model
      logic [7:0] cur;
      logic [7:0] rxb;
      int dly;
      int len;
      bit ab;
      spi_busy   = 1'b0;
      spi_rxdata = 8'h00;
      forever begin
         @(negedge clk);
         if (rst_n && spi_txstart) begin
            cur = spi_txdata;
            ab  = 1'b0;
            dly = int'($urandom_range(resp_max, resp_min));
            len = int'($urandom_range(16, 8));
            for (int i = 0; i < dly; i++) begin
               @(negedge clk);
               if (!rst_n) begin ab = 1'b1; break; end
               check("start_one_cycle", 32'(spi_txstart), 0);
               check("txdata_hold_wait", 32'(spi_txdata), 32'(cur));
            end
            if (!ab) begin
               spi_busy = 1'b1;
               for (int i = 0; i < len; i++) begin
                  @(negedge clk);
                  if (!rst_n) begin ab = 1'b1; break; end
                  check("txdata_hold_xfer", 32'(spi_txdata), 32'(cur));
               end
            end
            rxb        = miso_ones ? 8'hFF : cur;
            spi_rxdata = rxb;
            spi_busy   = 1'b0;
            if (!ab) begin
               nxfer++;
               check("xfer_expected", 32'(exp_tx_q.size() != 0), 1);
               if (exp_tx_q.size() != 0) check("tx_byte", 32'(cur), 32'(exp_tx_q.pop_front()));
               if (!rx_discard) exp_rx_q.push_back(rxb);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_tx(input logic [7:0] d);
      int g = 0;
      while (tx_full && g < 2000) begin @(negedge clk); g++; end
      check("tx_full_timeout", 32'(g < 2000), 1);
      tx_wr = 1'b1; tx_wdata = d; exp_tx_q.push_back(d);
      @(negedge clk);
      tx_wr = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int g = 0;
      while (seq_busy && g < 5000) begin @(negedge clk); g++; end
      check({tag, "_idle_timeout"}, 32'(g < 5000), 1);
   endtask

   task automatic pop_rx(input string tag);
      check({tag, "_rx_nonempty"}, 32'(rx_empty), 0);
      check({tag, "_rx_expected"}, 32'(exp_rx_q.size() != 0), 1);
      if (exp_rx_q.size() != 0) check({tag, "_rx_data"}, 32'(rx_rdata), 32'(exp_rx_q.pop_front()));
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
   endtask

   task automatic drain_all(input string tag);
      int g = 0;
      while ((seq_busy || !rx_empty) && g < 5000) begin
         if (!rx_empty) pop_rx(tag);
         else @(negedge clk);
         g++;
      end
      check({tag, "_drain_timeout"}, 32'(g < 5000), 1);
      check({tag, "_rx_left"}, 32'(exp_rx_q.size()), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_txdata"},  32'(spi_txdata), 0);
      check({tag, "_txstart"}, 32'(spi_txstart), 0);
      check({tag, "_rx_rdata"}, 32'(rx_rdata), 0);
      check({tag, "_tx_full"}, 32'(tx_full), 0);
      check({tag, "_rx_empty"}, 32'(rx_empty), 1);
      check({tag, "_rx_full"}, 32'(rx_full), 0);
      check({tag, "_seq_busy"}, 32'(seq_busy), 0);
   endtask

   initial begin : main
      int x0;
      int p0;
      int g;
      logic [7:0] d;
      rst_n = 1'b1; tx_wr = 1'b0; tx_wdata = 8'h00; rx_rd = 1'b0;
      auto_cnt_wr = 1'b0; auto_cnt_wdata = 8'h00; rx_discard = 1'b0;
      #2 rst_n = 1'b0;
      tick(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick(2);

      // 1: two looped-back bytes
      x0 = nxfer; p0 = nstart;
      write_tx(8'hA5);
      write_tx(8'h3C);
      wait_idle("s1");
      check("s1_xfers", 32'(nxfer - x0), 2);
      check("s1_starts", 32'(nstart - p0), 2);
      pop_rx("s1");
      pop_rx("s1");
      check("s1_rx_empty", 32'(rx_empty), 1);
      check("s1_seq_busy", 32'(seq_busy), 0);

      // 2: auto-read of three fill bytes, MISO high
      miso_ones = 1'b1;
      x0 = nxfer;
      auto_cnt_wr = 1'b1; auto_cnt_wdata = 8'd3;
      repeat (3) exp_tx_q.push_back(8'hFF);
      tick(1);
      auto_cnt_wr = 1'b0;
      wait_idle("s2");
      check("s2_xfers", 32'(nxfer - x0), 3);
      check("s2_rx_full", 32'(rx_full), 0);
      check("s2_rx_empty", 32'(rx_empty), 0);
      repeat (3) pop_rx("s2");
      check("s2_rx_empty_after", 32'(rx_empty), 1);

      // auto count of zero issues nothing
      x0 = nxfer;
      auto_cnt_wr = 1'b1; auto_cnt_wdata = 8'd0;
      tick(1);
      auto_cnt_wr = 1'b0;
      tick(20);
      check("s2_zero_xfers", 32'(nxfer - x0), 0);
      check("s2_zero_busy", 32'(seq_busy), 0);

      // TX byte beats auto-read when both appear together
      miso_ones = 1'b0;
      x0 = nxfer;
      d = 8'($urandom);
      tx_wr = 1'b1; tx_wdata = d; auto_cnt_wr = 1'b1; auto_cnt_wdata = 8'd2;
      exp_tx_q.push_back(d); exp_tx_q.push_back(8'hFF); exp_tx_q.push_back(8'hFF);
      tick(1);
      tx_wr = 1'b0; auto_cnt_wr = 1'b0;
      drain_all("s2p");
      check("s2p_xfers", 32'(nxfer - x0), 3);

      // count overwrite on the launch cycle: write wins, so 1 + 1 transfers
      x0 = nxfer;
      auto_cnt_wr = 1'b1; auto_cnt_wdata = 8'd200;
      tick(1);
      auto_cnt_wdata = 8'd1;
      tick(1);
      auto_cnt_wr = 1'b0;
      repeat (2) exp_tx_q.push_back(8'hFF);
      drain_all("s2w");
      check("s2w_xfers", 32'(nxfer - x0), 2);

      // 3: RX back-pressure stalls the sequencer
      x0 = nxfer;
      for (int i = 0; i < 6; i++) write_tx(8'($urandom));
      tick(300);
      check("s3_xfers_stall", 32'(nxfer - x0), 4);
      check("s3_rx_full", 32'(rx_full), 1);
      check("s3_seq_busy", 32'(seq_busy), 1);
      pop_rx("s3");
      tick(300);
      check("s3_xfers_after_pop", 32'(nxfer - x0), 5);
      check("s3_rx_full_again", 32'(rx_full), 1);
      drain_all("s3");
      check("s3_xfers_total", 32'(nxfer - x0), 6);

      // 4: discard mode never queues RX
      rx_discard = 1'b1;
      saw_rx = 1'b0;
      x0 = nxfer;
      for (int i = 0; i < 5; i++) write_tx(8'($urandom));
      wait_idle("s4");
      tick(3);
      check("s4_xfers", 32'(nxfer - x0), 5);
      check("s4_saw_rx", 32'(saw_rx), 0);
      check("s4_rx_empty", 32'(rx_empty), 1);
      rx_discard = 1'b0;

      // 5: slow controller response
      resp_min = 32; resp_max = 40;
      x0 = nxfer; p0 = nstart;
      write_tx(8'($urandom));
      write_tx(8'($urandom));
      drain_all("s5");
      check("s5_xfers", 32'(nxfer - x0), 2);
      check("s5_starts", 32'(nstart - p0), 2);
      resp_min = 1; resp_max = 3;

      // 6: reset during XFER
      write_tx(8'($urandom));
      g = 0;
      while (!spi_busy && g < 200) begin @(negedge clk); g++; end
      check("s6_busy_timeout", 32'(g < 200), 1);
      tick(2);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("s6_reset");
      exp_tx_q.delete();
      exp_rx_q.delete();
      x0 = nxfer;
      tick(3);
      rst_n = 1'b1;
      tick(40);
      check("s6_rx_empty", 32'(rx_empty), 1);
      check("s6_seq_busy", 32'(seq_busy), 0);
      check("s6_no_xfer", 32'(nxfer - x0), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
